// File: rtl/tile_lock_unit.sv
// ============================================================================
// Module   : tile_lock_unit
// Purpose  : Active-tile register set with commit-to-matrix and line-clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_lock_unit #(
  parameter int width_p  = 10,
  parameter int height_p = 20
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_v_i,
  input  logic [$clog2(width_p):0]      load_x_i,
  input  logic [$clog2(height_p):0]     load_y_i,
  input  logic [15:0]                   load_shape_i,
  output logic [$clog2(width_p):0]      pos_x_o,
  output logic [$clog2(height_p):0]     pos_y_o,
  output logic [15:0]                   shape_o,
  output logic                          is_empty_o,
  input  logic [$clog2(width_p)-1:0]    cell_x_i,
  input  logic [$clog2(height_p)-1:0]   cell_y_i,
  output logic                          cell_o,
  input  logic                          commit_v_i,
  input  logic                          check_v_i,
  output logic                          busy_o,
  output logic                          commit_done_o,
  output logic                          check_done_o,
  output logic [$clog2(height_p):0]     lines_o,
  output logic [$clog2(height_p)-1:0]   mm_read_addr_o,
  input  logic [width_p-1:0]            mm_read_data_i,
  output logic [$clog2(height_p)-1:0]   mm_write_addr_o,
  output logic [width_p-1:0]            mm_write_data_o,
  output logic                          mm_write_v_o
);

  localparam int c_XW  = $clog2(width_p) + 1;
  localparam int c_YW  = $clog2(height_p) + 1;
  localparam int c_AW  = $clog2(height_p);
  localparam int c_CXW = $clog2(width_p);
  // Signed working width: wide enough for any coordinate difference.
  localparam int c_SW  = ((c_YW > c_XW) ? c_YW : c_XW) + 2;

  localparam logic [c_AW-1:0] c_LAST  = c_AW'(height_p - 1);
  localparam logic [c_AW-1:0] c_ONE_A = c_AW'(1);
  localparam logic [c_YW-1:0] c_ONE_Y = c_YW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_COMMIT = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         r_state;
  logic [1:0]         r_step;
  logic               r_is_commit;
  logic [c_XW-1:0]    r_pos_x;
  logic [c_YW-1:0]    r_pos_y;
  logic [15:0]        r_shape;
  logic               r_empty;
  logic [c_AW-1:0]    r_rp;
  logic [c_AW-1:0]    r_wp;
  logic [c_YW-1:0]    r_count;
  logic [c_YW-1:0]    r_lines;

  logic [c_SW-1:0]    w_x_ext;
  logic [c_SW-1:0]    w_y_ext;
  logic [c_SW-1:0]    w_cell_dx;
  logic [c_SW-1:0]    w_cell_dy;
  logic [c_SW-1:0]    w_row;
  logic               w_row_ok;
  logic [3:0]         w_shape_row;
  logic [width_p-1:0] w_mask;
  logic               w_full;
  logic [c_YW-1:0]    w_count_next;
  logic               w_we;

  assign w_x_ext = {{(c_SW-c_XW){r_pos_x[c_XW-1]}}, r_pos_x};
  assign w_y_ext = {{(c_SW-c_YW){r_pos_y[c_YW-1]}}, r_pos_y};

  // Offsets in [0,4) are exactly those whose upper bits are all zero.
  assign w_cell_dx = {{(c_SW-c_CXW){1'b0}}, cell_x_i} - w_x_ext;
  assign w_cell_dy = {{(c_SW-c_AW){1'b0}}, cell_y_i} - w_y_ext;
  assign cell_o    = ~r_empty
                   & (w_cell_dx[c_SW-1:2] == '0)
                   & (w_cell_dy[c_SW-1:2] == '0)
                   & r_shape[{w_cell_dy[1:0], w_cell_dx[1:0]}];

  assign w_row       = w_y_ext + c_SW'(r_step);
  assign w_row_ok    = ~w_row[c_SW-1] && (w_row < c_SW'(height_p));
  assign w_shape_row = r_shape[{r_step, 2'b00} +: 4];

  for (genvar k = 0; k < width_p; k++) begin : g_mask
    logic [c_SW-1:0] w_dx;
    assign w_dx      = c_SW'(k) - w_x_ext;
    assign w_mask[k] = (w_dx[c_SW-1:2] == '0) & w_shape_row[w_dx[1:0]];
  end

  assign w_full       = &mm_read_data_i;
  assign w_count_next = w_full ? (r_count + c_ONE_Y) : r_count;

  always_comb begin
    mm_read_addr_o  = r_rp;
    mm_write_addr_o = r_wp;
    mm_write_data_o = '0;
    w_we            = 1'b0;
    case (r_state)
      S_COMMIT: begin
        mm_read_addr_o  = w_row[c_AW-1:0];
        mm_write_addr_o = w_row[c_AW-1:0];
        mm_write_data_o = mm_read_data_i | w_mask;
        w_we            = w_row_ok & (|w_shape_row);
      end
      S_SCAN: begin
        mm_write_data_o = mm_read_data_i;
        w_we            = ~w_full;
      end
      S_FILL: begin
        w_we            = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by reset so an aborting reset cannot land one last write.
  assign mm_write_v_o  = w_we & ~reset_i;

  assign busy_o        = (r_state != S_IDLE);
  assign commit_done_o = (r_state == S_DONE) &  r_is_commit;
  assign check_done_o  = (r_state == S_DONE) & ~r_is_commit;
  assign pos_x_o       = r_pos_x;
  assign pos_y_o       = r_pos_y;
  assign shape_o       = r_shape;
  assign is_empty_o    = r_empty;
  assign lines_o       = r_lines;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_step      <= '0;
      r_is_commit <= 1'b0;
      r_pos_x     <= '0;
      r_pos_y     <= '0;
      r_shape     <= '0;
      r_empty     <= 1'b1;
      r_rp        <= '0;
      r_wp        <= '0;
      r_count     <= '0;
      r_lines     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_v_i) begin
            r_pos_x <= load_x_i;
            r_pos_y <= load_y_i;
            r_shape <= load_shape_i;
            r_empty <= 1'b0;
          end
          if (commit_v_i) begin
            r_is_commit <= 1'b1;
            r_step      <= '0;
            r_state     <= r_empty ? S_DONE : S_COMMIT;
          end else if (check_v_i) begin
            r_is_commit <= 1'b0;
            r_count     <= '0;
            r_rp        <= c_LAST;
            r_wp        <= c_LAST;
            r_state     <= S_SCAN;
          end
        end
        S_COMMIT: begin
          r_step <= r_step + 2'd1;
          if (r_step == 2'd3) begin
            r_state <= S_DONE;
          end
        end
        S_SCAN: begin
          r_count <= w_count_next;
          r_rp    <= r_rp - c_ONE_A;
          if (!w_full) begin
            r_wp <= r_wp - c_ONE_A;
          end
          if (r_rp == '0) begin
            if (w_count_next == '0) begin
              r_lines <= '0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          r_wp <= r_wp - c_ONE_A;
          if (r_wp == '0) begin
            r_lines <= r_count;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_is_commit) begin
            r_empty <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_lock_unit.sv
// ============================================================================
// Module   : tb_tile_lock_unit
// Purpose  : Directed self-checking bench for tile_lock_unit with matrix model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_lock_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        load_v_i;
  logic [4:0]  load_x_i;
  logic [5:0]  load_y_i;
  logic [15:0] load_shape_i;
  logic [4:0]  pos_x_o;
  logic [5:0]  pos_y_o;
  logic [15:0] shape_o;
  logic        is_empty_o;
  logic [3:0]  cell_x_i;
  logic [4:0]  cell_y_i;
  logic        cell_o;
  logic        commit_v_i;
  logic        check_v_i;
  logic        busy_o;
  logic        commit_done_o;
  logic        check_done_o;
  logic [5:0]  lines_o;
  logic [4:0]  mm_read_addr_o;
  logic [9:0]  mm_read_data_i;
  logic [4:0]  mm_write_addr_o;
  logic [9:0]  mm_write_data_o;
  logic        mm_write_v_o;

  tile_lock_unit #(.width_p(10), .height_p(20)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .load_v_i(load_v_i), .load_x_i(load_x_i), .load_y_i(load_y_i),
    .load_shape_i(load_shape_i),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o), .shape_o(shape_o),
    .is_empty_o(is_empty_o),
    .cell_x_i(cell_x_i), .cell_y_i(cell_y_i), .cell_o(cell_o),
    .commit_v_i(commit_v_i), .check_v_i(check_v_i),
    .busy_o(busy_o), .commit_done_o(commit_done_o), .check_done_o(check_done_o),
    .lines_o(lines_o),
    .mm_read_addr_o(mm_read_addr_o), .mm_read_data_i(mm_read_data_i),
    .mm_write_addr_o(mm_write_addr_o), .mm_write_data_o(mm_write_data_o),
    .mm_write_v_o(mm_write_v_o)
  );

  always #5 clk = ~clk;

  // Matrix memory model: combinational read, write committed just after the edge.
  logic [9:0]  mem [20];
  int          wr_cnt;
  logic [31:0] wr_rows;
  int          n_cdone;
  int          n_kdone;
  logic [4:0]  wa;
  logic [9:0]  wd;

  assign mm_read_data_i = (mm_read_addr_o < 5'd20) ? mem[mm_read_addr_o] : 10'h000;

  always @(posedge clk) begin
    if (commit_done_o) n_cdone++;
    if (check_done_o)  n_kdone++;
    if (mm_write_v_o) begin
      wa = mm_write_addr_o;
      wd = mm_write_data_o;
      wr_cnt++;
      wr_rows = wr_rows | (32'd1 << wa);
      #1;
      if (wa < 5'd20) mem[wa] = wd;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 20; i++) mem[i] = 10'h000;
    wr_cnt  = 0;
    wr_rows = 32'd0;
    n_cdone = 0;
    n_kdone = 0;
  endtask

  task automatic load(input logic [4:0] x, input logic [5:0] y, input logic [15:0] s);
    load_v_i     = 1'b1;
    load_x_i     = x;
    load_y_i     = y;
    load_shape_i = s;
    tick();
    load_v_i = 1'b0;
  endtask

  // Start pulses are already set; returns the cycle count until the done pulse.
  task automatic run_until(input bit want_check, input int limit, output int cyc);
    tick();
    commit_v_i = 1'b0;
    check_v_i  = 1'b0;
    cyc = 1;
    while (!(want_check ? check_done_o : commit_done_o) && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;
  int snap;
  logic [9:0] acc;

  initial begin
    reset_i      = 1'b1;
    load_v_i     = 1'b0;
    load_x_i     = '0;
    load_y_i     = '0;
    load_shape_i = '0;
    commit_v_i   = 1'b0;
    check_v_i    = 1'b0;
    cell_x_i     = 4'd4;
    cell_y_i     = 5'd18;
    clear_mem();
    tick();
    tick();
    reset_i = 1'b0;
    tick(); tick(); tick();

    check("rst_empty",   is_empty_o, 1'b1);
    check("rst_lines",   lines_o, 6'd0);
    check("rst_busy",    busy_o, 1'b0);
    check("rst_shape",   shape_o, 16'h0000);
    check("rst_posx",    pos_x_o, 5'd0);
    check("rst_cell",    cell_o, 1'b0);
    check("rst_writes",  wr_cnt, 0);
    check("rst_dones",   n_cdone + n_kdone, 0);

    // Square-ish tile near the bottom.
    clear_mem();
    load(5'd3, 6'd18, 16'h0066);
    check("ld_empty",  is_empty_o, 1'b0);
    check("ld_posx",   pos_x_o, 5'd3);
    check("ld_posy",   pos_y_o, 6'd18);
    check("ld_shape",  shape_o, 16'h0066);
    cell_x_i = 4'd4; cell_y_i = 5'd18; #1;
    check("cell_4_18", cell_o, 1'b1);
    cell_x_i = 4'd3; cell_y_i = 5'd18; #1;
    check("cell_3_18", cell_o, 1'b0);
    cell_x_i = 4'd5; cell_y_i = 5'd19; #1;
    check("cell_5_19", cell_o, 1'b1);
    cell_x_i = 4'd6; cell_y_i = 5'd19; #1;
    check("cell_6_19", cell_o, 1'b0);

    commit_v_i = 1'b1;
    run_until(1'b0, 12, cyc);
    check("cm1_cycles",   cyc, 5);
    check("cm1_busy",     busy_o, 1'b1);
    check("cm1_empty_in_done", is_empty_o, 1'b0);
    tick();
    check("cm1_row18",    mem[18], 10'h030);
    check("cm1_row19",    mem[19], 10'h030);
    check("cm1_wrcnt",    wr_cnt, 2);
    check("cm1_wrrows",   wr_rows, 32'h000C_0000);
    check("cm1_empty",    is_empty_o, 1'b1);
    check("cm1_done_1cy", commit_done_o, 1'b0);
    check("cm1_idle",     busy_o, 1'b0);

    // Two full bottom rows, one partial above.
    clear_mem();
    mem[17] = 10'h001;
    mem[18] = 10'h3FF;
    mem[19] = 10'h3FF;
    check_v_i = 1'b1;
    run_until(1'b1, 40, cyc);
    check("ck1_cycles", cyc, 23);
    check("ck1_lines_in_done", lines_o, 6'd2);
    tick();
    check("ck1_row19",  mem[19], 10'h001);
    acc = 10'h000;
    for (int i = 0; i < 19; i++) acc = acc | mem[i];
    check("ck1_upper_zero", acc, 10'h000);
    check("ck1_wrcnt",  wr_cnt, 20);
    check("ck1_lines_hold", lines_o, 6'd2);
    check("ck1_done_1cy", check_done_o, 1'b0);
    check("ck1_tile_untouched", is_empty_o, 1'b1);

    // Tile hanging off the left edge.
    clear_mem();
    mem[0] = 10'h200;
    load(5'h1F, 6'd0, 16'h0033);
    commit_v_i = 1'b1;
    run_until(1'b0, 12, cyc);
    check("cm2_cycles", cyc, 5);
    tick();
    check("cm2_row0",  mem[0], 10'h201);
    check("cm2_row1",  mem[1], 10'h001);
    check("cm2_wrcnt", wr_cnt, 2);

    // Commit with no tile.
    clear_mem();
    commit_v_i = 1'b1;
    run_until(1'b0, 12, cyc);
    check("cm_empty_cycles", cyc, 1);
    tick();
    check("cm_empty_wrcnt", wr_cnt, 0);
    check("cm_empty_idle",  busy_o, 1'b0);

    // Commit wins over a simultaneous check.
    clear_mem();
    load(5'd0, 6'd5, 16'h000F);
    commit_v_i = 1'b1;
    check_v_i  = 1'b1;
    run_until(1'b0, 12, cyc);
    check("prio_cycles", cyc, 5);
    tick();
    tick();
    check("prio_row5",   mem[5], 10'h00F);
    check("prio_wrcnt",  wr_cnt, 1);
    check("prio_no_check", n_kdone, 0);
    check("prio_idle",   busy_o, 1'b0);
    check("prio_lines",  lines_o, 6'd2);

    // Load ignored while busy, then reset mid-scan.
    clear_mem();
    check_v_i = 1'b1;
    tick();
    check_v_i = 1'b0;
    tick();
    tick();
    check("scan_busy",  busy_o, 1'b1);
    check("scan_write", mm_write_v_o, 1'b1);
    load_v_i     = 1'b1;
    load_x_i     = 5'd7;
    load_y_i     = 6'd9;
    load_shape_i = 16'hFFFF;
    tick();
    load_v_i = 1'b0;
    check("busy_load_posx",  pos_x_o, 5'd0);
    check("busy_load_shape", shape_o, 16'h000F);
    reset_i = 1'b1;
    tick();
    snap = wr_cnt;
    check("abort_wv",    mm_write_v_o, 1'b0);
    check("abort_busy",  busy_o, 1'b0);
    check("abort_empty", is_empty_o, 1'b1);
    check("abort_lines", lines_o, 6'd0);
    check("abort_shape", shape_o, 16'h0000);
    reset_i = 1'b0;
    tick(); tick(); tick();
    check("abort_no_writes", wr_cnt, snap);
    check("abort_no_done",   n_kdone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tile_lock_unit.md
# tile_lock_unit

Holds the active falling tile and performs the two playfield-mutating operations of the Tetris core: committing the tile into the playfield matrix and eliminating full lines. It sits between the game-plate sequencer and the row-addressed matrix memory. Every matrix access goes through one combinational-read row port and one synchronous-write row port.

## Interface
- width_p, 10, playfield columns
- height_p, 20, playfield rows; row 0 is the top row and row height_p-1 is the bottom row
- clk_i  in  1  clock
- reset_i  in  1  reset; one clock, synchronous, active-high
- load_v_i  in  1  load a new active tile
- load_x_i  in  $clog2(width_p)+1  signed tile origin column
- load_y_i  in  $clog2(height_p)+1  signed tile origin row
- load_shape_i  in  16  4x4 shape; bit r*4+c is cell (row y+r, column x+c)
- pos_x_o, pos_y_o, shape_o  out  as load  current tile registers
- is_empty_o  out  1  no active tile
- cell_x_i / cell_y_i  in  $clog2(width_p) / $clog2(height_p)  display query cell
- cell_o  out  1  active tile occupies the queried cell (combinational)
- commit_v_i  in  1  start commit
- check_v_i  in  1  start line check
- busy_o  out  1  a commit or check is in progress
- commit_done_o, check_done_o  out  1  one-cycle completion pulses
- lines_o  out  $clog2(height_p)+1  rows eliminated by the last check
- mm_read_addr_o  out  $clog2(height_p)  row to read
- mm_read_data_i  in  width_p  row contents, valid in the same cycle; bit k is column k
- mm_write_addr_o  out  $clog2(height_p)  row to write
- mm_write_data_o  out  width_p  data to write
- mm_write_v_o  out  1  row write enable, applied at the clock edge

## Operation
- Reset values: is_empty_o=1; pos=0; shape=0; lines_o=0; busy_o, both done outputs and mm_write_v_o=0.
- Load: accepted only when idle. Registers the position and shape and clears is_empty_o. A load while busy is ignored.
- cell_o is 1 when all of the following hold:
  - the tile is not empty;
  - 0 ≤ cell_x−x < 4 and 0 ≤ cell_y−y < 4, computed signed;
  - shape bit[(cell_y−y)*4 + (cell_x−x)] is set.
- Start priority when idle: commit_v_i takes priority over check_v_i. Start requests while busy are ignored.
- Commit, non-empty tile: FSM IDLE → COMMIT(r=0..3) → DONE.
  - In step r, mm_read_addr = y+r.
  - Mask = shape row r placed at columns x..x+3. Columns outside 0..width_p−1 are dropped.
  - Write data = read data OR mask.
  - mm_write_v_o is asserted only when 0 ≤ y+r < height_p and the shape row is non-zero.
  - In DONE: commit_done_o=1 and is_empty_o is set on the same edge that leaves DONE.
- Commit, empty tile: IDLE → DONE. No writes occur.
- Check: FSM IDLE → SCAN → FILL → DONE.
  - On start: lines counter cleared; read pointer rp = write pointer wp = height_p−1.
  - SCAN, one row per cycle, reads row rp:
    - row all ones: count+1, rp−1, no write;
    - otherwise: write that row to wp, then wp−1 and rp−1. The write still occurs when wp==rp.
  - After row 0 is scanned: FILL writes zeros to rows wp down to 0, one per cycle. FILL is skipped when no row was eliminated.
  - DONE: check_done_o=1. lines_o updates at entry to DONE and holds until the next check completes.
- The tile registers are not modified by a check.

## Timing
- Commit: 4 step cycles, then DONE on the 5th cycle after start; busy_o is high for those 5 cycles. Empty commit: DONE on the cycle after start.
- Check: height_p SCAN cycles, then n FILL cycles (n = rows eliminated), then 1 DONE cycle.
- Done pulses last exactly one cycle. The unit is idle and accepts a new start in the cycle after DONE.
- A reset mid-operation aborts the operation immediately: no further writes, all outputs return to their reset values, and matrix contents are left as they are.

## Test plan
- Reset, then idle for 3 cycles → is_empty_o=1, lines_o=0, mm_write_v_o never asserted, cell_o=0.
- Load shape 0x0066 at x=3, y=18, then commit on an all-zero matrix → writes row 18=0x030 and row 19=0x030 and no other rows; commit_done_o on the 5th cycle; is_empty_o=1 afterwards.
- Rows 18 and 19 = 0x3FF, row 17 = 0x001, all others 0; check → lines_o=2; row 19=0x001, rows 0..18=0; check_done_o in the 23rd cycle.
- Load shape 0x0033 at x=−1, y=0 onto row 0=0x200 → row 0 becomes 0x201 and row 1 becomes 0x001; the column −1 bits are dropped.
- commit_v_i while the tile is empty → commit_done_o on the next cycle, no writes. Simultaneous commit_v_i and check_v_i with a loaded tile → only the commit executes.
- With the second scenario's tile loaded: query (4,18) → cell_o=1; query (3,18) → cell_o=0. Assert reset during a check SCAN → mm_write_v_o=0 from the next cycle.
